// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - byte-addressed little-endian data memory with wait states and error responses
module byte_data_memory #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error
);

    localparam int              IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam logic [IDX_W:0]  DEPTH_IDX = (IDX_W + 1)'(DEPTH_BYTES);
    localparam logic [3:0]      WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic              l_write;
    logic [ADDR_W-1:0] l_addr;
    logic [1:0]        l_size;
    logic              l_signed;
    logic [31:0]       l_wdata;

    logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

    logic [2:0]        nbytes;
    logic              misaligned;
    logic              out_of_range;
    logic              access_error;
    logic [ADDR_W:0]   end_addr;
    logic [IDX_W:0]    idx_sum [4];
    logic [IDX_W-1:0]  idx     [4];
    logic [31:0]       raw;
    logic [31:0]       load_data;
    logic              complete;
    logic              do_write;

    assign req_ready = (state == IDLE) && !reset;
    assign complete  = (state == BUSY) && (count == 4'd0);
    assign do_write  = complete && l_write && !access_error && !reset;

    // End address is formed one bit wider so addresses near the top of the space cannot wrap.
    always_comb begin
        nbytes     = 3'd0;
        misaligned = 1'b0;
        case (l_size)
            2'b00: nbytes = 3'd1;
            2'b01: begin
                nbytes     = 3'd2;
                misaligned = l_addr[0];
            end
            2'b10: begin
                nbytes     = 3'd4;
                misaligned = |l_addr[1:0];
            end
            default: nbytes = 3'd0;
        endcase
        end_addr     = {1'b0, l_addr} + (ADDR_W + 1)'(nbytes);
        out_of_range = end_addr > DEPTH_EXT;
        access_error = (l_size == 2'b11) || misaligned || out_of_range;
    end

    // Byte lanes past the end of the array fold back onto the base byte; only reached on rejected accesses.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx_sum[k] = {1'b0, l_addr[IDX_W-1:0]} + (IDX_W + 1)'(k);
            idx[k]     = (idx_sum[k] < DEPTH_IDX) ? idx_sum[k][IDX_W-1:0] : l_addr[IDX_W-1:0];
        end
        raw = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
        case (l_size)
            2'b00:   load_data = l_signed ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b01:   load_data = l_signed ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: load_data = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx[0]] <= l_wdata[7:0];
            if (nbytes >= 3'd2) begin
                mem[idx[1]] <= l_wdata[15:8];
            end
            if (nbytes == 3'd4) begin
                mem[idx[2]] <= l_wdata[23:16];
                mem[idx[3]] <= l_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0;
            l_write    <= 1'b0;
            l_addr     <= '0;
            l_size     <= 2'b00;
            l_signed   <= 1'b0;
            l_wdata    <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_write  <= req_write;
                        l_addr   <= req_addr;
                        l_size   <= req_size;
                        l_signed <= req_signed;
                        l_wdata  <= req_wdata;
                        count    <= WAIT_INIT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_error <= access_error;
                        resp_rdata <= (l_write || access_error) ? 32'h0 : load_data;
                        state      <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// tb/tb_byte_data_memory.sv - randomized and directed checks of byte_data_memory at LATENCY 1 and 4
module tb_byte_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        vld  [2];
    logic        rdy  [2];
    logic        rv   [2];
    logic [31:0] rd   [2];
    logic        re   [2];
    logic        wr_b;
    logic [31:0] addr_b;
    logic [1:0]  size_b;
    logic        sgn_b;
    logic [31:0] wdata_b;

    logic [7:0]  mdl [2][1024];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    byte_data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr_b), .req_addr(addr_b), .req_size(size_b), .req_signed(sgn_b),
        .req_wdata(wdata_b), .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_error(re[0])
    );

    byte_data_memory #(.DEPTH_BYTES(1024), .ADDR_W(32), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr_b), .req_addr(addr_b), .req_size(size_b), .req_signed(sgn_b),
        .req_wdata(wdata_b), .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_error(re[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input int w, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd,
                         output logic e_err, output logic [31:0] e_rd);
        int n;
        longint unsigned last;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        e_rd = 32'h0;
        if (n == 0) begin
            e_err = 1'b1;
        end else begin
            last  = {32'h0, a} + longint'(n);
            e_err = ((a % n) != 0) || (last > 1024);
        end
        if (!e_err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) mdl[w][a + i] = 8'((wd >> (8 * i)) & 32'hFF);
                else    e_rd = e_rd | (32'(mdl[w][a + i]) << (8 * i));
            end
            if (!wr && sg && n < 4 && e_rd[8 * n - 1])
                e_rd = e_rd | ~((32'd1 << (8 * n)) - 32'd1);
        end
    endtask

    task automatic do_access(input int w, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                             input logic sg, input logic [31:0] wd, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd;
        int          lat;
        lat = (w == 0) ? 1 : 4;
        @(negedge clk);
        check("ready_idle", 32'(rdy[w]), 32'd1);
        wr_b = wr; addr_b = a; size_b = sz; sgn_b = sg; wdata_b = wd; vld[w] = 1'b1;
        @(posedge clk);
        #1;
        vld[w] = 1'b0; addr_b = $urandom; wdata_b = $urandom;
        model(w, wr, a, sz, sg, wd, e_err, e_rd);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("busy_ready", 32'(rdy[w]), 32'd0);
            check("busy_rvalid", 32'(rv[w]), 32'd0);
        end
        @(negedge clk);
        check("resp_valid", 32'(rv[w]), 32'd1);
        check("resp_ready", 32'(rdy[w]), 32'd1);
        check("resp_error", 32'(re[w]), 32'(e_err));
        check("resp_rdata", rd[w], e_rd);
        got = rd[w];
        @(negedge clk);
        check("pulse_end", 32'(rv[w]), 32'd0);
        check("rdata_hold", rd[w], e_rd);
        check("error_hold", 32'(re[w]), 32'(e_err));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)       return 32'($urandom_range(0, 63));
        else if (r < 8)  return 32'($urandom_range(1000, 1023));
        else if (r == 8) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else             return $urandom;
    endfunction

    initial begin
        logic [31:0] got;
        int          acc[$];
        int          rsp[$];
        int          rdy_low;
        int          seen;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 1024; i++) mdl[w][i] = 8'h00;
        reset = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0;
        wr_b = 1'b0; addr_b = 32'h0; size_b = 2'd0; sgn_b = 1'b0; wdata_b = 32'h0;

        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            check("rst_ready", 32'(rdy[w]), 32'd0);
            check("rst_rvalid", 32'(rv[w]), 32'd0);
            check("rst_rdata", rd[w], 32'd0);
            check("rst_error", 32'(re[w]), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready0", 32'(rdy[0]), 32'd1);
        check("post_rst_ready1", 32'(rdy[1]), 32'd1);

        do_access(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, got);
        check("st_word_rdata", got, 32'h0);
        do_access(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got);
        check("ld_word", got, 32'hDEADBEEF);
        do_access(0, 1'b0, 32'h10, 2'd0, 1'b0, 32'h0, got);
        check("ld_byte_10", got, 32'h0000_00EF);
        do_access(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, got);
        check("ld_sbyte_13", got, 32'hFFFF_FFDE);
        do_access(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, got);
        check("ld_ubyte_13", got, 32'h0000_00DE);
        do_access(0, 1'b0, 32'h12, 2'd1, 1'b1, 32'h0, got);
        check("ld_shalf_12", got, 32'hFFFF_DEAD);
        do_access(0, 1'b1, 32'h10, 2'd1, 1'b0, 32'h0000_1234, got);
        do_access(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got);
        check("ld_after_half", got, 32'hDEAD_1234);

        do_access(0, 1'b1, 32'h11, 2'd2, 1'b0, 32'hFFFF_FFFF, got);
        do_access(0, 1'b1, 32'h13, 2'd1, 1'b0, 32'hFFFF_FFFF, got);
        do_access(0, 1'b1, 32'h3FE, 2'd2, 1'b0, 32'hFFFF_FFFF, got);
        do_access(0, 1'b1, 32'h0, 2'd3, 1'b0, 32'hFFFF_FFFF, got);
        do_access(0, 1'b0, 32'h11, 2'd2, 1'b0, 32'h0, got);
        check("err_load_rdata", got, 32'h0);
        do_access(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got);
        check("err_mem_kept", got, 32'hDEAD_1234);
        do_access(0, 1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0, got);
        check("err_top_kept", got, 32'h0);

        for (int n = 0; n < 120; n++)
            do_access(0, 1'($urandom), rand_addr(), 2'($urandom), 1'($urandom), $urandom, got);

        // Back-to-back word loads on the LATENCY=4 instance with valid held high.
        rdy_low = 0;
        @(negedge clk);
        wr_b = 1'b0; addr_b = 32'h0; size_b = 2'd2; sgn_b = 1'b0; vld[1] = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clk);
            if (acc.size() == 3) vld[1] = 1'b0;
            if (vld[1] && rdy[1]) acc.push_back(c);
            if (rv[1]) rsp.push_back(c);
            if (c >= 1 && c <= 4 && !rdy[1]) rdy_low++;
        end
        vld[1] = 1'b0;
        check("b2b_acc_count", 32'(acc.size()), 32'd3);
        check("b2b_rsp_count", 32'(rsp.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_accept_cycle", 32'((acc.size() > i) ? acc[i] : -1), 32'(5 * i));
            check("b2b_resp_cycle", 32'((rsp.size() > i) ? rsp[i] : -1), 32'(5 * i + 5));
        end
        check("b2b_ready_low", 32'(rdy_low), 32'd4);

        do_access(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344, got);
        @(negedge clk);
        wr_b = 1'b1; addr_b = 32'h20; size_b = 2'd2; sgn_b = 1'b0; wdata_b = 32'hCAFE_F00D; vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_rst_ready", 32'(rdy[1]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(rdy[1]), 32'd1);
        check("abort_rdata", rd[1], 32'h0);
        check("abort_error", 32'(re[1]), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rv[1]) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        do_access(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, got);
        check("abort_mem_kept", got, 32'h1122_3344);

        for (int n = 0; n < 40; n++)
            do_access(1, 1'($urandom), rand_addr(), 2'($urandom), 1'($urandom), $urandom, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
